// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, buffer entry type and PC helper for the fetch stage
package fetch_unit_pkg;
  localparam int XLEN = 32;
  localparam int PC_STEP = 4;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~32'd3;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous power-of-two FIFO with synchronous clear and occupancy count
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clr,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    count = cnt_q;
    rdata = mem_q[rd_q];
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = clr ? '0 : wr_q + AW'(do_push);
    rd_d = clr ? '0 : rd_q + AW'(do_pop);
    cnt_d = clr ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    mem_d = mem_q;
    if (do_push && !clr) mem_d[wr_q] = wdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and instruction fetch stage feeding the control decoder
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_target
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d, discard_q, discard_d, occ;
  logic [XLEN-1:0] aq_q [FIFO_DEPTH];
  logic [XLEN-1:0] aq_d [FIFO_DEPTH];
  logic [AW-1:0] aw_q, aw_d, ar_q, ar_d;
  logic run_q, req_fire, rsp_keep, pop, full, empty;
  fetch_entry_t head;
  always_comb begin
    imem_req_valid = run_q && !redirect_en && ({1'b0, inflight_q} + {1'b0, occ}) < (CW+1)'(FIFO_DEPTH);
    imem_req_addr = pc_q;
    req_fire = imem_req_valid && imem_req_ready;
    rsp_keep = imem_rsp_valid && !redirect_en && discard_q == '0;
    instr_valid = !empty;
    pop = instr_valid && instr_ready;
    instr = empty ? NOP_INSTR : head.instr;
    instr_pc = empty ? '0 : head.pc;
    pc_d = redirect_en ? word_align(redirect_target) : req_fire ? pc_q + XLEN'(PC_STEP) : pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d = redirect_en ? inflight_q - CW'(imem_rsp_valid)
                            : discard_q - CW'(imem_rsp_valid && discard_q != '0);
    aw_d = aw_q + AW'(req_fire);
    ar_d = ar_q + AW'(imem_rsp_valid);
    aq_d = aq_q;
    if (req_fire) aq_d[aw_q] = pc_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_q <= RESET_PC;
      inflight_q <= '0;
      discard_q <= '0;
      aw_q <= '0;
      ar_q <= '0;
      run_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      discard_q <= discard_d;
      aw_q <= aw_d;
      ar_q <= ar_d;
      run_q <= 1'b1;
    end
  always_ff @(posedge clk) aq_q <= aq_d;
  // The credit rule reserves a slot for every accepted response
  always_ff @(posedge clk) if (rst_n) assert (!(rsp_keep && full && !pop));
  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(rsp_keep),
    .pop(pop),
    .clr(redirect_en),
    .wdata({aq_q[ar_q], imem_rsp_data}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(occ)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench with a latency-configurable in-order memory model
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid, instr_ready, redirect_en;
  logic [31:0] imem_req_addr, imem_rsp_data, instr, instr_pc, redirect_target;
  typedef struct {
    logic [31:0] addr;
    int due;
  } req_t;
  req_t pend[$];
  logic [63:0] sb[$];
  int checks = 0, failures = 0, cyc = 0, lat = 1, last_due = 0;
  logic popped, fired, rsp_seen;
  logic [31:0] popped_pc, fired_addr;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .redirect_en(redirect_en),
    .redirect_target(redirect_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic cycle();
    logic [63:0] exp;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if (pend.size() > 0)
      if (pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = word(pend[0].addr);
      end
    #1;
    popped = instr_valid && instr_ready;
    fired = imem_req_valid && imem_req_ready;
    rsp_seen = imem_rsp_valid;
    if (popped) begin
      popped_pc = instr_pc;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL instr_unexpected got pc=%h instr=%h required=none", instr_pc, instr);
      end else begin
        exp = sb.pop_front();
        if ({instr_pc, instr} !== exp) begin
          failures++;
          $display("FAIL instr_order got pc=%h instr=%h required pc=%h instr=%h",
                   instr_pc, instr, exp[63:32], exp[31:0]);
        end
      end
    end
    if (redirect_en) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL req_in_redirect got=%b required=0", imem_req_valid);
      end
      sb.delete();
    end
    if (fired) begin
      fired_addr = imem_req_addr;
      checks++;
      if (imem_req_addr[1:0] !== 2'b00) begin
        failures++;
        $display("FAIL req_align got=%h required low bits 00", imem_req_addr);
      end
      last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      pend.push_back('{imem_req_addr, last_due});
      sb.push_back({imem_req_addr, word(imem_req_addr)});
    end
    if (imem_rsp_valid) void'(pend.pop_front());
    checks++;
    if (sb.size() > 2) begin
      failures++;
      $display("FAIL credit got outstanding=%0d required<=2", sb.size());
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc} !== {1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0}) begin
      failures++;
      $display("FAIL reset_values got req_v=%b addr=%h iv=%b instr=%h pc=%h required 0 0 0 %h 0",
               imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, NOP_INSTR);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_fetch();
    int n = 0, c0 = 0, c1 = 0;
    logic [31:0] p0 = '1, p1 = '1;
    bit got_req = 0;
    lat = 1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 3 && !got_req; k++) begin
      cycle();
      if (fired) begin
        got_req = 1;
        checks++;
        if (fired_addr !== 32'h0) begin
          failures++;
          $display("FAIL first_req_addr got=%h required=00000000", fired_addr);
        end
      end
    end
    checks++;
    if (!got_req) begin
      failures++;
      $display("FAIL first_req_timeout got=none required=request within 3 cycles");
    end
    for (int k = 0; k < 20 && n < 2; k++) begin
      cycle();
      if (popped) begin
        if (n == 0) begin p0 = popped_pc; c0 = cyc; end
        else begin p1 = popped_pc; c1 = cyc; end
        n++;
      end
    end
    checks++;
    if (p0 !== 32'h0 || p1 !== 32'h4) begin
      failures++;
      $display("FAIL first_pcs got=%h,%h required=00000000,00000004", p0, p1);
    end
    checks++;
    if (c1 != c0 + 1) begin
      failures++;
      $display("FAIL first_consecutive got gap=%0d required=1", c1 - c0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a;
    int pops = 0;
    imem_req_ready = 1'b0;
    cycle();
    a = imem_req_addr;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (imem_req_addr !== a) begin
        failures++;
        $display("FAIL addr_stable got=%h required=%h", imem_req_addr, a);
      end
    end
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) cycle();
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_full got req_v=%b iv=%b required req_v=0 iv=1", imem_req_valid, instr_valid);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (popped) pops++;
    end
    checks++;
    if (pops < 2) begin
      failures++;
      $display("FAIL bp_release got pops=%0d required>=2", pops);
    end
  endtask

  task automatic test_redirect_inflight();
    bit got = 0, seen = 0;
    int k_pop = 0;
    lat = 3;
    instr_ready = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      if (pend.size() == 2) got = 1;
      else cycle();
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL redir_setup got inflight=%0d required=2", pend.size());
    end
    redirect_en = 1'b1;
    redirect_target = 32'h100;
    cycle();
    redirect_en = 1'b0;
    checks++;
    if (imem_req_addr !== 32'h100) begin
      failures++;
      $display("FAIL redir_addr got=%h required=00000100", imem_req_addr);
    end
    for (int k = 1; k <= 20 && !seen; k++) begin
      cycle();
      if (popped) begin seen = 1; k_pop = k; end
    end
    checks++;
    if (!seen || popped_pc !== 32'h100 || k_pop < 3) begin
      failures++;
      $display("FAIL redir_first got seen=%b pc=%h after=%0d required pc=00000100 after>=3", seen, popped_pc, k_pop);
    end
  endtask

  task automatic test_redirect_coincident();
    bit found = 0;
    lat = 1;
    instr_ready = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      if (instr_valid && pend.size() > 0)
        if (pend[0].due <= cyc) found = 1;
      if (!found) cycle();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL coinc_setup got=none required=pop and response in one cycle");
    end else begin
      redirect_en = 1'b1;
      redirect_target = 32'h200;
      cycle();
      redirect_en = 1'b0;
      checks++;
      if (popped !== 1'b1 || rsp_seen !== 1'b1) begin
        failures++;
        $display("FAIL coinc_events got pop=%b rsp=%b required 1 1", popped, rsp_seen);
      end
      checks++;
      if (instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL coinc_empty got iv=%b required=0", instr_valid);
      end
    end
    for (int k = 0; k < 6; k++) cycle();
  endtask

  task automatic test_misaligned_wrap();
    bit f1 = 0, f2 = 0;
    lat = 1;
    redirect_en = 1'b1;
    redirect_target = 32'hFFFF_FFFE;
    cycle();
    redirect_en = 1'b0;
    checks++;
    if (imem_req_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_target got=%h required=fffffffc", imem_req_addr);
    end
    for (int k = 0; k < 10 && !f1; k++) begin cycle(); f1 = fired; end
    checks++;
    if (!f1 || fired_addr !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_first got fired=%b addr=%h required=fffffffc", f1, fired_addr);
    end
    for (int k = 0; k < 10 && !f2; k++) begin cycle(); f2 = fired; end
    checks++;
    if (!f2 || fired_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next got fired=%b addr=%h required=00000000", f2, fired_addr);
    end
    for (int k = 0; k < 6; k++) cycle();
  endtask

  task automatic test_async_reset();
    int pops = 0;
    instr_ready = 1'b1;
    for (int k = 0; k < 10 && !instr_valid; k++) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_addr !== 32'h0 || imem_req_valid !== 1'b0 || instr !== NOP_INSTR) begin
      failures++;
      $display("FAIL async_reset got iv=%b addr=%h req_v=%b instr=%h required 0 00000000 0 %h",
               instr_valid, imem_req_addr, imem_req_valid, instr, NOP_INSTR);
    end
    pend.delete();
    sb.delete();
    imem_rsp_valid = 1'b0;
    last_due = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (popped) pops++;
    end
    checks++;
    if (pops < 1) begin
      failures++;
      $display("FAIL restart got pops=%0d required>=1", pops);
    end
  endtask

  task automatic test_drain();
    imem_req_ready = 1'b0;
    instr_ready = 1'b1;
    for (int k = 0; k < 40 && (sb.size() > 0 || pend.size() > 0); k++) cycle();
    checks++;
    if (sb.size() != 0 || pend.size() != 0) begin
      failures++;
      $display("FAIL drain got sb=%0d pend=%0d required 0 0", sb.size(), pend.size());
    end
  endtask

  initial begin
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    instr_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_target = '0;
    test_reset();
    test_first_fetch();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_misaligned_wrap();
    test_async_reset();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
